// File: rtl/ascii_frame_tx_pkg.sv
// Shared definitions for the ASCII telemetry frame transmitter: FSM encoding,
// frame character constants, frame lengths and the captured-input snapshot.
package ascii_frame_tx_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    localparam logic [7:0] CharX     = 8'h58;
    localparam logic [7:0] CharY     = 8'h59;
    localparam logic [7:0] CharZ     = 8'h5A;
    localparam logic [7:0] CharT     = 8'h54;
    localparam logic [7:0] CharColon = 8'h3A;
    localparam logic [7:0] CharPlus  = 8'h2B;
    localparam logic [7:0] CharMinus = 8'h2D;
    localparam logic [7:0] CharCr    = 8'h0D;
    localparam logic [7:0] CharLf    = 8'h0A;

    localparam int unsigned FrameLenCrlf = 35;
    localparam int unsigned FrameLenLf   = 34;
    localparam int unsigned IdxW         = 6;
    localparam int unsigned NumDigits    = 18;

    // digits[0..3]=X1..X4, [4..7]=Y1..Y4, [8..11]=Z1..Z4, [12..17]=T1..T6; neg = {T,Z,Y,X}
    typedef struct packed {
        logic [NumDigits-1:0][7:0] digits;
        logic [3:0]                neg;
    } snapshot_t;

    function automatic logic [7:0] sign_char(input logic neg);
        return neg ? CharMinus : CharPlus;
    endfunction

endpackage

// File: rtl/ascii_frame_tx_if.sv
// Byte-stream valid/ready handshake towards the UART transmitter.
interface ascii_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ascii_frame_tx_frame_byte_mux.sv
// Combinational lookup from frame byte index to the frame byte, built from the snapshot.
module frame_byte_mux
    import ascii_frame_tx_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter bit         EOL_CRLF = 1'b1
) (
    input  snapshot_t       snap_i,
    input  logic [IdxW-1:0] idx_i,
    output logic [7:0]      byte_o
);

    localparam int unsigned FrameLen = EOL_CRLF ? FrameLenCrlf : FrameLenLf;

    logic [7:0] frame [FrameLenCrlf];

    always_comb begin
        frame[0]  = CharX;
        frame[1]  = CharColon;
        frame[2]  = sign_char(snap_i.neg[0]);
        frame[7]  = SEP_CHAR;
        frame[8]  = CharY;
        frame[9]  = CharColon;
        frame[10] = sign_char(snap_i.neg[1]);
        frame[15] = SEP_CHAR;
        frame[16] = CharZ;
        frame[17] = CharColon;
        frame[18] = sign_char(snap_i.neg[2]);
        frame[23] = SEP_CHAR;
        frame[24] = CharT;
        frame[25] = CharColon;
        frame[26] = sign_char(snap_i.neg[3]);
        for (int i = 0; i < 4; i++) begin
            frame[3 + i]  = snap_i.digits[i];
            frame[11 + i] = snap_i.digits[4 + i];
            frame[19 + i] = snap_i.digits[8 + i];
        end
        for (int i = 0; i < 6; i++) begin
            frame[27 + i] = snap_i.digits[12 + i];
        end
        // LF-only frames end one byte early; the spare slot is never addressed.
        frame[33] = EOL_CRLF ? CharCr : CharLf;
        frame[34] = EOL_CRLF ? CharLf : 8'h00;
    end

    assign byte_o = (idx_i < IdxW'(FrameLen)) ? frame[idx_i] : 8'h00;

endmodule

// File: rtl/ascii_frame_tx.sv
// Serialises a snapshot of X/Y/Z/T ASCII readings into one text frame over a
// valid/ready byte stream; all outputs are registered.
module ascii_frame_tx
    import ascii_frame_tx_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter bit         EOL_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       ascii_X1,
    input  logic [7:0]       ascii_X2,
    input  logic [7:0]       ascii_X3,
    input  logic [7:0]       ascii_X4,
    input  logic [7:0]       ascii_Y1,
    input  logic [7:0]       ascii_Y2,
    input  logic [7:0]       ascii_Y3,
    input  logic [7:0]       ascii_Y4,
    input  logic [7:0]       ascii_Z1,
    input  logic [7:0]       ascii_Z2,
    input  logic [7:0]       ascii_Z3,
    input  logic [7:0]       ascii_Z4,
    input  logic [7:0]       ascii_T1,
    input  logic [7:0]       ascii_T2,
    input  logic [7:0]       ascii_T3,
    input  logic [7:0]       ascii_T4,
    input  logic [7:0]       ascii_T5,
    input  logic [7:0]       ascii_T6,
    input  logic             is_negative_X,
    input  logic             is_negative_Y,
    input  logic             is_negative_Z,
    input  logic             is_negative_T,
    ascii_frame_tx_if.master tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     FrameLen = EOL_CRLF ? FrameLenCrlf : FrameLenLf;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(FrameLen - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    snapshot_t       snap_q, snap_d, in_snap;
    logic [7:0]      data_q, data_d, mux_byte;
    logic            valid_q, busy_q, done_q, done_d;

    assign in_snap.digits = {ascii_T6, ascii_T5, ascii_T4, ascii_T3, ascii_T2, ascii_T1,
                             ascii_Z4, ascii_Z3, ascii_Z2, ascii_Z1,
                             ascii_Y4, ascii_Y3, ascii_Y2, ascii_Y1,
                             ascii_X4, ascii_X3, ascii_X2, ascii_X1};
    assign in_snap.neg    = {is_negative_T, is_negative_Z, is_negative_Y, is_negative_X};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // The done cycle still counts as busy for start qualification.
                if (start && !done_q) begin
                    snap_d  = in_snap;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx.tx_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    frame_byte_mux #(
        .SEP_CHAR (SEP_CHAR),
        .EOL_CRLF (EOL_CRLF)
    ) u_frame_byte_mux (
        .snap_i (snap_d),
        .idx_i  (idx_d),
        .byte_o (mux_byte)
    );

    assign data_d = (state_d == StSend) ? mux_byte : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= (state_d == StSend);
            busy_q  <= (state_d == StSend);
            done_q  <= done_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ascii_frame_tx.sv
// Directed self-checking bench for ascii_frame_tx (CRLF and LF-only instances).
module tb_ascii_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2;
    logic [7:0] ax [4];
    logic [7:0] ay [4];
    logic [7:0] az [4];
    logic [7:0] at [6];
    logic       nx, ny, nz, nt;
    logic       busy, done, busy2, done2;
    int         checks = 0;
    int         errors = 0;

    ascii_frame_tx_if tx1 ();
    ascii_frame_tx_if tx2 ();

    always #5 clk = ~clk;

    ascii_frame_tx dut (
        .clk (clk), .reset (reset), .start (start),
        .ascii_X1 (ax[0]), .ascii_X2 (ax[1]), .ascii_X3 (ax[2]), .ascii_X4 (ax[3]),
        .ascii_Y1 (ay[0]), .ascii_Y2 (ay[1]), .ascii_Y3 (ay[2]), .ascii_Y4 (ay[3]),
        .ascii_Z1 (az[0]), .ascii_Z2 (az[1]), .ascii_Z3 (az[2]), .ascii_Z4 (az[3]),
        .ascii_T1 (at[0]), .ascii_T2 (at[1]), .ascii_T3 (at[2]),
        .ascii_T4 (at[3]), .ascii_T5 (at[4]), .ascii_T6 (at[5]),
        .is_negative_X (nx), .is_negative_Y (ny), .is_negative_Z (nz), .is_negative_T (nt),
        .tx (tx1), .busy (busy), .done (done)
    );

    ascii_frame_tx #(
        .EOL_CRLF (1'b0)
    ) dut_lf (
        .clk (clk), .reset (reset), .start (start2),
        .ascii_X1 (8'h30), .ascii_X2 (8'h30), .ascii_X3 (8'h30), .ascii_X4 (8'h30),
        .ascii_Y1 (8'h30), .ascii_Y2 (8'h30), .ascii_Y3 (8'h30), .ascii_Y4 (8'h30),
        .ascii_Z1 (8'h30), .ascii_Z2 (8'h30), .ascii_Z3 (8'h30), .ascii_Z4 (8'h30),
        .ascii_T1 (8'h30), .ascii_T2 (8'h30), .ascii_T3 (8'h30),
        .ascii_T4 (8'h30), .ascii_T5 (8'h30), .ascii_T6 (8'h30),
        .is_negative_X (1'b0), .is_negative_Y (1'b0), .is_negative_Z (1'b0),
        .is_negative_T (1'b0),
        .tx (tx2), .busy (busy2), .done (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input string x, input string y, input string z, input string t,
                          input logic [3:0] n);
        for (int i = 0; i < 4; i++) begin
            ax[i] = x[i];
            ay[i] = y[i];
            az[i] = z[i];
        end
        for (int i = 0; i < 6; i++) at[i] = t[i];
        {nt, nz, ny, nx} = n;
    endtask

    // Entered at the sample point showing byte 0; returns at the done sample point.
    task automatic run_frame(input bit sel, input string exp, input bit rnd,
                             input int restart_at, input bit chk_consec);
        int         i   = 0;
        int         cyc = 0;
        int         len = exp.len();
        bit         r;
        logic [7:0] held;
        while (i < len && cyc < 400) begin
            check("valid_mid", sel ? tx2.tx_valid : tx1.tx_valid, 1);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) tx2.tx_ready = r; else tx1.tx_ready = r;
            held = sel ? tx2.tx_data : tx1.tx_data;
            if (r) begin
                check($sformatf("byte%0d", i), held, exp[i]);
                i++;
            end
            if (i == restart_at) begin
                set_in("9999", "9999", "9999", "999999", 4'hF);
                start      = 1'b1;
                restart_at = -1;
            end
            tick();
            cyc++;
            start = 1'b0;
            if (!r) check("hold", sel ? tx2.tx_data : tx1.tx_data, held);
        end
        check("frame_len", i, len);
        if (chk_consec) check("consec", cyc, len);
        check("done_pulse", sel ? done2 : done, 1);
        check("busy_end", sel ? busy2 : busy, 0);
        check("valid_end", sel ? tx2.tx_valid : tx1.tx_valid, 0);
        if (sel) tx2.tx_ready = 1'b0; else tx1.tx_ready = 1'b0;
    endtask

    initial begin
        string exp_a;
        string exp_e;
        exp_a = "X:-0123 Y:+0007 Z:+2047 T:-131071\r\n";
        exp_e = "X:+0000 Y:+0000 Z:+0000 T:+000000\n";
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        tx1.tx_ready = 1'b0;
        tx2.tx_ready = 1'b0;
        set_in("0123", "0007", "2047", "131071", 4'b1001);
        #1;
        check("rst_valid", tx1.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", tx1.tx_data, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Basic frame with tx_ready held high.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_busy", busy, 1);
        run_frame(0, exp_a, 0, -1, 1);

        // start during done is ignored, start the next cycle is accepted.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", busy, 0);
        check("ign_valid", tx1.tx_valid, 0);
        check("ign_done", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        // Same frame under random backpressure.
        run_frame(0, exp_a, 1, -1, 0);
        tick();
        check("done_once_b", done, 0);

        // Inputs and start re-pulsed mid-frame must not disturb the snapshot.
        set_in("0123", "0007", "2047", "131071", 4'b1001);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(0, exp_a, 0, 10, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_second_done", done, 0);
            check("no_second_busy", busy, 0);
        end

        // Reset mid-frame aborts without done.
        set_in("0123", "0007", "2047", "131071", 4'b1001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tx1.tx_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("pre_abort_data", tx1.tx_data, exp_a[20]);
        reset = 1'b1;
        #1;
        check("abort_valid", tx1.tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_data", tx1.tx_data, 8'h00);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_abort_valid", tx1.tx_valid, 0);
            check("post_abort_done", done, 0);
        end
        tx1.tx_ready = 1'b0;

        // LF-only instance, all-zero positive readings.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("lf_busy", busy2, 1);
        run_frame(1, exp_e, 0, -1, 1);
        tick();
        check("lf_done_once", done2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_frame_tx.md
ASCII_FRAME_TX -- requirements
Module: ascii_frame_tx

Interface
REQ-001 Parameter: SEP_CHAR, default 8'h20, separator byte between the X/Y/Z/T fields.
REQ-002 Parameter: EOL_CRLF, default 1; 1 = frame ends CR,LF; 0 = frame ends LF only.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to snapshot inputs and send one frame.
REQ-006 ascii_X1..ascii_X4, ascii_Y1..ascii_Y4, ascii_Z1..ascii_Z4  in  8 each  ASCII digits, MSD first.
REQ-007 ascii_T1..ascii_T6  in  8 each  ASCII digits, MSD first.
REQ-008 is_negative_X, is_negative_Y, is_negative_Z, is_negative_T  in  1 each  sign flags.
REQ-009 tx_data  out  8  current frame byte to the UART transmitter.
REQ-010 tx_valid  out  1  tx_data is valid; byte transfers on a cycle with tx_valid && tx_ready.
REQ-011 tx_ready  in  1  transmitter can accept a byte.
REQ-012 busy  out  1  high while a frame is in progress.
REQ-013 done  out  1  one-cycle pulse after the last byte of a frame transfers.

Function
REQ-014 Frame byte order SHALL be: 'X' ':' sX X1 X2 X3 X4 SEP 'Y' ':' sY Y1..Y4 SEP 'Z' ':' sZ Z1..Z4 SEP 'T' ':' sT T1..T6 [CR] LF.
REQ-015 Frame length SHALL be 35 bytes with EOL_CRLF=1 and 34 bytes with EOL_CRLF=0.
REQ-016 The sign byte SHALL be 8'h2D ('-') when the flag is 1 and 8'h2B ('+') when it is 0.
REQ-017 Leading zero digits SHALL be transmitted unchanged, with no blanking.
REQ-018 FSM states SHALL be IDLE and SEND only.
REQ-019 IDLE: when start=1, the block SHALL register all 18 digit inputs and 4 sign flags into a snapshot, clear the byte index to 0, and enter SEND on the next edge.
REQ-020 SEND: tx_valid SHALL be 1, and tx_data SHALL be the byte at the current index, taken from the snapshot only.
REQ-021 On a transfer (tx_valid && tx_ready) that is not the last byte, the index SHALL increment by 1.
REQ-022 On the transfer of the last byte, the FSM SHALL return to IDLE and done SHALL pulse for exactly the following cycle.
REQ-023 While tx_ready=0 in SEND, tx_data and the index SHALL hold stable.
REQ-024 tx_valid SHALL never deassert mid-frame before its byte transfers.
REQ-025 start SHALL be ignored while busy=1, including in the cycle done is high.
REQ-026 Input changes after the snapshot SHALL NOT affect the frame in progress.
REQ-027 busy SHALL be 1 exactly while in SEND.
REQ-028 Latency: the first byte SHALL be valid the cycle after start; with tx_ready held at 1, a frame SHALL take 35 consecutive cycles (EOL_CRLF=1).
REQ-029 tx_data, tx_valid, busy and done SHALL be registered outputs (Moore), with no combinational path from tx_ready to tx_valid.

Reset
REQ-030 When reset is asserted, the block SHALL asynchronously enter IDLE.
REQ-031 Reset SHALL force tx_valid=0, busy=0, done=0, tx_data=8'h00, index=0, and the snapshot to all zeros.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-033 After reset deasserts, the block SHALL require a new start before sending.

Structure
REQ-034 The shared package SHALL hold: the FSM state encoding, the character constants ('X','Y','Z','T',':','+','-',CR 8'h0D, LF 8'h0A), and the frame-length constants.
REQ-035 The block SHALL contain one sub-module, frame_byte_mux: a combinational index-to-byte lookup over the snapshot; all other logic SHALL live in the top level.

Verification
REQ-036 X=-0123, Y=+0007, Z=+2047, T=-131071, start, tx_ready=1 -> 35 bytes "X:-0123 Y:+0007 Z:+2047 T:-131071\r\n" on consecutive cycles, then done pulses once.
REQ-037 tx_ready toggling 1-0-0-1 randomly during a frame -> the byte stream is identical to REQ-036, and tx_data is stable whenever tx_valid && !tx_ready.
REQ-038 Inputs changed and start re-pulsed at byte 10 -> the frame still carries the original snapshot, the second start is ignored, and only one done pulse occurs.
REQ-039 reset asserted at byte 20 -> tx_valid, busy and done drop to 0 immediately, and no further bytes transfer until the next start.
REQ-040 EOL_CRLF=0, all inputs '0' and positive -> a 34-byte frame "X:+0000 Y:+0000 Z:+0000 T:+000000\n".
REQ-041 start pulsed in the same cycle as done -> ignored; start pulsed the next cycle -> a new frame begins one cycle later.
